uart_rx_fsm: RTL
================

Name: uart_rx_fsm

Overview:
- Receive-path controller for the UART RX.
- Generates the bit-timing count (edge_cnt) and sample enable consumed by the data sampler.
- Consumes the sampler's resolved bit (sampled_bit) and steps through start/data/parity/stop.
- Deserializes the data bits, checks parity and stop, and emits a one-cycle data_valid with the parallel byte toward the RX clock-domain synchronizer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, sent LSB first.

Ports:
- CLK  input  1  oversampling clock, Prescale cycles per bit
- RST  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, already synchronized to CLK, idle high
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32; quasi-static, must not change mid-frame
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even, 1 = odd
- sampled_bit  input  1  resolved bit value from the data sampler
- edge_cnt  output  5  edge position within the current bit, 0..Prescale-1
- dat_samp_en  output  1  sampler enable
- P_DATA  output  DATA_WIDTH  last good received word
- data_valid  output  1  one-cycle pulse, P_DATA is new
- par_err  output  1  parity mismatch on current/last frame
- stp_err  output  1  stop bit sampled low on current/last frame

Behaviour:
- Reset values: state IDLE; edge_cnt=0; bit counter=0; dat_samp_en=0; P_DATA=0; data_valid=0; par_err=0; stp_err=0; shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- dat_samp_en=1 in every state except IDLE.
- edge_cnt:
  - Held 0 in IDLE; the first cycle in START shows edge_cnt=0.
  - Otherwise increments each CLK and wraps to 0 after Prescale-1.
  - The wrap cycle is the "bit end" (BE).
- Evaluation point: sampled_bit is consumed only on the BE cycle (edge_cnt==Prescale-1). This gives the 3-sample majority sampler its two-cycle result latency at every legal Prescale.
- IDLE -> START: when RX_IN==0 and Prescale is 8, 16 or 32. Any other Prescale keeps the block in IDLE, with frames ignored.
- On entering START: clear par_err, stp_err and the bit counter.
- START at BE:
  - sampled_bit==0: go to DATA.
  - sampled_bit==1: glitch; go to IDLE with no flags and no data_valid.
- DATA:
  - At each BE, store sampled_bit into shift register index bit_cnt (LSB first), then increment bit_cnt.
  - After bit DATA_WIDTH-1: go to PARITY if PAR_EN, else STOP.
- PARITY at BE:
  - Expected bit = XOR(data) for even, ~XOR(data) for odd.
  - Mismatch sets par_err.
  - Go to STOP.
- STOP at BE:
  - sampled_bit==0 sets stp_err.
  - If stp_err and par_err are both clear after this check: P_DATA <= shift register, and data_valid pulses high for exactly the next cycle.
  - Next state: START if RX_IN==0 in that same cycle (back-to-back frame, edge_cnt restarts at 0); otherwise IDLE.
- Error flags hold until the next START entry. P_DATA is unchanged on errored or glitched frames.
- Latency: data_valid is high the cycle after stop-bit BE. For 8N1 at Prescale 8, that is 80 cycles after the START entry cycle.
- Reset mid-frame: immediate return to reset values; any partial word is discarded.

Decomposition:
- Shared uart_pkg:
  - state encoding (localparam enum).
  - legal prescale constants PRESC_8/16/32.
  - parity type constants PAR_EVEN=0, PAR_ODD=1.
- One natural sub-module, uart_edge_bit_counter: owns edge_cnt and bit_cnt, with enable, wrap at Prescale-1, and a bit-end strobe. The FSM, deserializer and parity/stop checks stay in uart_rx_fsm.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> data_valid one-cycle pulse 88 cycles after START entry, P_DATA=0xA5, par_err=0, stp_err=0.
- Prescale=8, RX_IN low for 2 cycles then high -> start rejected, return to IDLE at edge_cnt 7, no data_valid, P_DATA unchanged.
- Prescale=16, PAR_TYP=1, data 0x3C with parity bit driven 0 -> par_err=1, no data_valid, P_DATA holds previous value; next good frame clears par_err on START entry.
- Prescale=16, PAR_EN=0, data 0x5A with stop bit 0 -> stp_err=1, no data_valid.
- Prescale=32, PAR_EN=0, frames 0x01 and 0xFF back-to-back with no idle -> two data_valid pulses exactly 320 cycles apart, P_DATA 0x01 then 0xFF.
- Reset asserted at edge 3 of data bit 4, then released with a clean 0x81 frame -> all outputs 0 during reset, then P_DATA=0x81 with a single data_valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART RX definitions: FSM state encoding, legal oversampling ratios,
// parity type codes and a prescale legality helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frames are only accepted at one of the supported oversampling ratios.
  function automatic logic presc_legal(input logic [5:0] p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Bit-timing counter: edge position within the current bit (wraps at
// Prescale-1, held at 0 while disabled), bit-end strobe, and data bit index.
module uart_edge_bit_counter #(
  parameter int BIT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [5:0]       Prescale,
  input  logic             bit_clr,
  input  logic             bit_inc,
  output logic [4:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             bit_end
);

  // Last edge of a bit; Prescale is at most 32 so Prescale-1 fits edge_cnt.
  assign bit_end = en && ({1'b0, edge_cnt} == (Prescale - 6'd1));

  // Edge counter: free-runs while enabled, restarts at 0 on every bit end.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                edge_cnt <= '0;
    else if (!en || bit_end) edge_cnt <= '0;
    else                     edge_cnt <= edge_cnt + 5'd1;
  end

  // Data bit index: cleared while framing the start bit, stepped per data bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         bit_cnt <= '0;
    else if (bit_clr) bit_cnt <= '0;
    else if (bit_inc) bit_cnt <= bit_cnt + BIT_W'(1);
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: walks start/data/parity/stop on bit-end cycles,
// deserializes LSB first, checks parity and stop, and pulses data_valid for
// one cycle when a clean word lands in P_DATA.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [4:0]            edge_cnt,
  output logic                  dat_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_end;
  logic                  exp_par;
  logic                  last_bit;

  // dat_samp_en is exactly "not IDLE", so it doubles as the counter enable.
  uart_edge_bit_counter #(.BIT_W(BIT_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (dat_samp_en),
    .Prescale (Prescale),
    .bit_clr  (state == START),
    .bit_inc  ((state == DATA) && bit_end),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  assign exp_par  = (PAR_TYP == PAR_ODD) ? ~(^shift_reg) : (^shift_reg);
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  // Frame FSM with registered outputs; sampled_bit is only consumed at bit end.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      dat_samp_en <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      shift_reg   <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN && presc_legal(Prescale)) begin
            state       <= START;
            dat_samp_en <= 1'b1;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (sampled_bit) begin
              // Start bit did not hold low: line glitch, drop quietly.
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            // Shift in from the top; after DATA_WIDTH bits the first lands at bit 0.
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if (last_bit) state <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_end) begin
            if (sampled_bit != exp_par) par_err <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!sampled_bit) stp_err <= 1'b1;
            if (sampled_bit && !par_err) begin
              P_DATA     <= shift_reg;
              data_valid <= 1'b1;
            end
            if (!RX_IN) begin
              // Next start bit already on the line: chain without an idle cycle.
              state   <= START;
              par_err <= 1'b0;
              stp_err <= 1'b0;
            end else begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
